// File: rtl/board_score_counter.sv
// rtl/board_score_counter.sv - snapshot-and-scan white/black/empty piece counter
// Scans LANES cells per cycle from a board snapshot and publishes all results together.
module board_score_counter #(
    parameter int                N_CELLS    = 64,
    parameter int                CELL_W     = 3,
    parameter logic [CELL_W-1:0] WHITE_CODE = 3'b110,
    parameter logic [CELL_W-1:0] BLACK_CODE = 3'b111,
    parameter int                LANES      = 1,
    localparam int               SCORE_W    = $clog2(N_CELLS + 1),
    localparam int               STEPS      = N_CELLS / LANES
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        init,
    input  logic                        start,
    input  logic [N_CELLS*CELL_W-1:0]   curr_board,
    output logic                        busy,
    output logic                        count_done,
    output logic [SCORE_W-1:0]          score_white,
    output logic [SCORE_W-1:0]          score_black,
    output logic [SCORE_W-1:0]          score_empty,
    output logic [1:0]                  leader,
    output logic                        all_filled,
    output logic                        wiped
);

    localparam logic [SCORE_W-1:0] ONE        = SCORE_W'(1);
    localparam logic [SCORE_W-1:0] LANES_W    = SCORE_W'(LANES);
    localparam logic [SCORE_W-1:0] LAST_IDX   = SCORE_W'((STEPS - 1) * LANES);
    localparam logic [SCORE_W-1:0] N_CELLS_W  = SCORE_W'(N_CELLS);
    localparam logic [SCORE_W-1:0] OPEN_COUNT = SCORE_W'(2);
    localparam logic [SCORE_W-1:0] OPEN_EMPTY = SCORE_W'(N_CELLS - 4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_PUBLISH
    } state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic                        w_accept;
    logic [N_CELLS*CELL_W-1:0]   r_snap;
    logic [SCORE_W-1:0]          r_idx;
    logic [SCORE_W-1:0]          r_acc_w;
    logic [SCORE_W-1:0]          r_acc_b;
    logic [SCORE_W-1:0]          w_hit_w;
    logic [SCORE_W-1:0]          w_hit_b;
    logic [SCORE_W-1:0]          w_empty;
    logic [1:0]                  w_leader;

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next   = S_SCAN;
                    w_accept = 1'b1;
                end
            end
            S_SCAN: begin
                if (r_idx == LAST_IDX) begin
                    w_next = S_PUBLISH;
                end
            end
            S_PUBLISH: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
        if (init) begin
            w_next   = S_IDLE;
            w_accept = 1'b0;
        end
    end

    // The snapshot shifts down each scan cycle, so its low LANES cells are always cells idx..idx+LANES-1.
    always_comb begin
        w_hit_w = '0;
        w_hit_b = '0;
        for (int l = 0; l < LANES; l++) begin
            if (r_snap[l*CELL_W +: CELL_W] == WHITE_CODE) begin
                w_hit_w = w_hit_w + ONE;
            end
            if (r_snap[l*CELL_W +: CELL_W] == BLACK_CODE) begin
                w_hit_b = w_hit_b + ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_snap  <= '0;
            r_idx   <= '0;
            r_acc_w <= '0;
            r_acc_b <= '0;
        end else if (w_accept) begin
            r_snap  <= curr_board;
            r_idx   <= '0;
            r_acc_w <= '0;
            r_acc_b <= '0;
        end else if (r_state == S_SCAN && !init) begin
            r_snap  <= r_snap >> (LANES * CELL_W);
            r_idx   <= r_idx + LANES_W;
            r_acc_w <= r_acc_w + w_hit_w;
            r_acc_b <= r_acc_b + w_hit_b;
        end
    end

    assign w_empty = N_CELLS_W - r_acc_w - r_acc_b;

    always_comb begin
        w_leader = 2'b00;
        if (r_acc_w > r_acc_b) begin
            w_leader = 2'b01;
        end else if (r_acc_b > r_acc_w) begin
            w_leader = 2'b10;
        end
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            count_done  <= 1'b0;
            score_white <= OPEN_COUNT;
            score_black <= OPEN_COUNT;
            score_empty <= OPEN_EMPTY;
            leader      <= 2'b00;
            all_filled  <= 1'b0;
            wiped       <= 1'b0;
        end else if (init) begin
            count_done  <= 1'b0;
            score_white <= OPEN_COUNT;
            score_black <= OPEN_COUNT;
            score_empty <= OPEN_EMPTY;
            leader      <= 2'b00;
            all_filled  <= 1'b0;
            wiped       <= 1'b0;
        end else if (r_state == S_PUBLISH) begin
            count_done  <= 1'b1;
            score_white <= r_acc_w;
            score_black <= r_acc_b;
            score_empty <= w_empty;
            leader      <= w_leader;
            all_filled  <= (w_empty == '0);
            // One colour gone implies the other is present, so the board cannot be empty here.
            wiped       <= (r_acc_w == '0) ^ (r_acc_b == '0);
        end else begin
            count_done  <= 1'b0;
        end
    end

    assign busy = (r_state == S_SCAN);

endmodule

// File: tb/tb_board_score_counter.sv
// tb/tb_board_score_counter.sv - directed self-checking bench for board_score_counter
module tb_board_score_counter;

    logic         clk = 1'b0;
    logic         resetn;
    logic         init;
    logic         start;
    logic         start4;
    logic [191:0] board;
    logic [191:0] board4;
    logic         busy, count_done, all_filled, wiped;
    logic [6:0]   score_white, score_black, score_empty;
    logic [1:0]   leader;
    logic         busy4, count_done4, all_filled4, wiped4;
    logic [6:0]   score_white4, score_black4, score_empty4;
    logic [1:0]   leader4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    board_score_counter dut (
        .clk(clk), .resetn(resetn), .init(init), .start(start), .curr_board(board),
        .busy(busy), .count_done(count_done), .score_white(score_white),
        .score_black(score_black), .score_empty(score_empty), .leader(leader),
        .all_filled(all_filled), .wiped(wiped)
    );

    board_score_counter #(.LANES(4)) dut4 (
        .clk(clk), .resetn(resetn), .init(init), .start(start4), .curr_board(board4),
        .busy(busy4), .count_done(count_done4), .score_white(score_white4),
        .score_black(score_black4), .score_empty(score_empty4), .leader(leader4),
        .all_filled(all_filled4), .wiped(wiped4)
    );

    function automatic logic [191:0] fill(input logic [2:0] code);
        logic [191:0] b;
        for (int i = 0; i < 64; i++) b[i*3 +: 3] = code;
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller sets start before calling; the first tick is the accepting edge k.
    task automatic run_count(input int max_cyc, output int n_done, output int at);
        n_done = 0;
        at     = -1;
        tick();
        start = 1'b0;
        for (int j = 1; j <= max_cyc; j++) begin
            tick();
            if (count_done) begin
                n_done++;
                if (at < 0) at = j;
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b1; init = 1'b0; start = 1'b0; start4 = 1'b0;
        board = '0; board4 = '0;
        tick(); tick();
        n_checks++;
        if ({score_white, score_black, score_empty} !== {7'd2, 7'd2, 7'd60}) begin
            n_fail++;
            $display("FAIL reset_scores: got %0d/%0d/%0d expected 2/2/60", score_white, score_black, score_empty);
        end
        n_checks++;
        if ({leader, all_filled, wiped, busy, count_done} !== 6'b00_0000) begin
            n_fail++;
            $display("FAIL reset_flags: got leader=%b af=%b wp=%b busy=%b done=%b expected 00 0 0 0 0",
                     leader, all_filled, wiped, busy, count_done);
        end
        n_checks++;
        if ({score_empty4, busy4, count_done4} !== {7'd60, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_lanes4: got empty=%0d busy=%b done=%b expected 60 0 0", score_empty4, busy4, count_done4);
        end
        #1 resetn = 1'b0;
        tick();
    endtask

    task automatic test_idle();
        logic [27:0] ref_v;
        int changes = 0;
        ref_v = {score_white, score_black, score_empty, leader, all_filled, wiped, busy, count_done};
        for (int j = 0; j < 100; j++) begin
            tick();
            if ({score_white, score_black, score_empty, leader, all_filled, wiped, busy, count_done} !== 28'({7'd2, 7'd2, 7'd60, 2'b00, 4'b0000}))
                changes++;
            if ({score_white, score_black, score_empty, leader, all_filled, wiped, busy, count_done} !== ref_v)
                changes++;
        end
        n_checks++;
        if (changes !== 0) begin
            n_fail++;
            $display("FAIL idle_hold: got %0d output changes expected 0", changes);
        end
    endtask

    task automatic test_opening();
        int n = 0, at = -1;
        logic busy63 = 1'b0, busy64 = 1'b1;
        board = '0;
        board[27*3 +: 3] = 3'b110; board[36*3 +: 3] = 3'b110;
        board[28*3 +: 3] = 3'b111; board[35*3 +: 3] = 3'b111;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 1; j <= 80; j++) begin
            tick();
            if (j == 63) busy63 = busy;
            if (j == 64) busy64 = busy;
            if (count_done) begin
                n++;
                if (at < 0) at = j;
            end
        end
        n_checks++;
        if (n !== 1 || at !== 65) begin
            n_fail++;
            $display("FAIL opening_latency: got %0d pulses at k+%0d expected 1 at k+65", n, at);
        end
        n_checks++;
        if ({busy63, busy64} !== 2'b10) begin
            n_fail++;
            $display("FAIL opening_busy: got busy(k+63)=%b busy(k+64)=%b expected 1 0", busy63, busy64);
        end
        n_checks++;
        if ({score_white, score_black, score_empty, leader, all_filled, wiped} !== {7'd2, 7'd2, 7'd60, 2'b00, 2'b00}) begin
            n_fail++;
            $display("FAIL opening_result: got %0d/%0d/%0d leader=%b af=%b wp=%b expected 2/2/60 00 0 0",
                     score_white, score_black, score_empty, leader, all_filled, wiped);
        end
    endtask

    task automatic test_invalid_codes();
        int n, at;
        board = fill(3'b101);
        board[0*3 +: 3] = 3'b111; board[1*3 +: 3] = 3'b111; board[2*3 +: 3] = 3'b111;
        board[62*3 +: 3] = 3'b111; board[63*3 +: 3] = 3'b111;
        start = 1'b1;
        run_count(75, n, at);
        n_checks++;
        if (n !== 1 || at !== 65) begin
            n_fail++;
            $display("FAIL invalid_latency: got %0d pulses at k+%0d expected 1 at k+65", n, at);
        end
        n_checks++;
        if ({score_white, score_black, score_empty, leader, all_filled, wiped} !== {7'd0, 7'd5, 7'd59, 2'b10, 2'b01}) begin
            n_fail++;
            $display("FAIL invalid_result: got %0d/%0d/%0d leader=%b af=%b wp=%b expected 0/5/59 10 0 1",
                     score_white, score_black, score_empty, leader, all_filled, wiped);
        end
    endtask

    task automatic test_snapshot();
        int n = 0, at = -1, changed = 0;
        board = '0;
        board[27*3 +: 3] = 3'b110; board[36*3 +: 3] = 3'b110;
        board[28*3 +: 3] = 3'b111; board[35*3 +: 3] = 3'b111;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 1; j <= 80; j++) begin
            if (j == 10) begin
                board = fill(3'b111);
                start = 1'b1;
            end
            if (j == 11) start = 1'b0;
            tick();
            if (count_done) begin
                n++;
                if (at < 0) at = j;
            end
            if (j < 65 && {score_white, score_black, score_empty} !== {7'd0, 7'd5, 7'd59}) changed++;
        end
        n_checks++;
        if (n !== 1 || at !== 65) begin
            n_fail++;
            $display("FAIL snapshot_pulses: got %0d pulses at k+%0d expected 1 at k+65", n, at);
        end
        n_checks++;
        if (changed !== 0) begin
            n_fail++;
            $display("FAIL snapshot_hold: got %0d early output changes expected 0", changed);
        end
        n_checks++;
        if ({score_white, score_black, score_empty} !== {7'd2, 7'd2, 7'd60}) begin
            n_fail++;
            $display("FAIL snapshot_result: got %0d/%0d/%0d expected 2/2/60", score_white, score_black, score_empty);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0, at1 = -1, at2 = -1;
        logic [24:0] r1 = '0, r2 = '0;
        board = fill(3'b110);
        for (int i = 0; i < 33; i++) board[i*3 +: 3] = 3'b111;
        start = 1'b1;
        tick();
        board = '0;
        for (int i = 0; i < 40; i++) board[i*3 +: 3] = 3'b110;
        for (int i = 40; i < 43; i++) board[i*3 +: 3] = 3'b111;
        for (int j = 1; j <= 140; j++) begin
            if (j == 67) start = 1'b0;
            tick();
            if (count_done) begin
                n++;
                if (n == 1) begin
                    at1 = j;
                    r1  = {score_white, score_black, score_empty, leader, all_filled, wiped};
                end else begin
                    at2 = j;
                    r2  = {score_white, score_black, score_empty, leader, all_filled, wiped};
                end
            end
        end
        n_checks++;
        if (n !== 2 || at1 !== 65 || at2 !== 131) begin
            n_fail++;
            $display("FAIL b2b_timing: got %0d pulses at k+%0d,k+%0d expected 2 at k+65,k+131", n, at1, at2);
        end
        n_checks++;
        if (r1 !== {7'd31, 7'd33, 7'd0, 2'b10, 2'b10}) begin
            n_fail++;
            $display("FAIL b2b_first: got %h expected %h", r1, {7'd31, 7'd33, 7'd0, 2'b10, 2'b10});
        end
        n_checks++;
        if (r2 !== {7'd40, 7'd3, 7'd21, 2'b01, 2'b00}) begin
            n_fail++;
            $display("FAIL b2b_second: got %h expected %h", r2, {7'd40, 7'd3, 7'd21, 2'b01, 2'b00});
        end
    endtask

    task automatic test_reset_mid_scan();
        int n = 0, at = -1;
        board = fill(3'b111);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 30; j++) tick();
        resetn = 1'b1;
        #1;
        n_checks++;
        if ({score_white, score_black, score_empty, leader, busy, count_done} !== {7'd2, 7'd2, 7'd60, 2'b00, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %0d/%0d/%0d leader=%b busy=%b done=%b expected 2/2/60 00 0 0",
                     score_white, score_black, score_empty, leader, busy, count_done);
        end
        tick();
        #1 resetn = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_restart: got busy=%b expected 1", busy);
        end
        for (int j = 1; j <= 75; j++) begin
            tick();
            if (count_done) begin
                n++;
                if (at < 0) at = j;
            end
        end
        n_checks++;
        if (n !== 1 || at !== 65 || score_black !== 7'd64) begin
            n_fail++;
            $display("FAIL reset_mid_count: got %0d pulses at k+%0d black=%0d expected 1 at k+65 black=64", n, at, score_black);
        end
    endtask

    task automatic test_init_mid_scan();
        int n, at;
        board = fill(3'b110);
        for (int i = 0; i < 33; i++) board[i*3 +: 3] = 3'b111;
        start = 1'b1;
        run_count(70, n, at);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 1; j < 20; j++) tick();
        init = 1'b1;
        tick();
        init = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL init_mid_busy: got busy=%b expected 0", busy);
        end
        n_checks++;
        if ({score_white, score_black, score_empty, leader, all_filled, wiped} !== {7'd2, 7'd2, 7'd60, 2'b00, 2'b00}) begin
            n_fail++;
            $display("FAIL init_mid_scores: got %0d/%0d/%0d leader=%b af=%b wp=%b expected 2/2/60 00 0 0",
                     score_white, score_black, score_empty, leader, all_filled, wiped);
        end
        n = 0;
        for (int j = 0; j < 80; j++) begin
            tick();
            if (count_done) n++;
        end
        n_checks++;
        if (n !== 0) begin
            n_fail++;
            $display("FAIL init_mid_nodone: got %0d pulses expected 0", n);
        end
    endtask

    task automatic test_init_start_same();
        int n = 0, nb = 0;
        board = fill(3'b111);
        init  = 1'b1;
        start = 1'b1;
        tick();
        init  = 1'b0;
        start = 1'b0;
        for (int j = 0; j < 80; j++) begin
            tick();
            if (count_done) n++;
            if (busy) nb++;
        end
        n_checks++;
        if (n !== 0 || nb !== 0 || score_black !== 7'd2) begin
            n_fail++;
            $display("FAIL init_start_drop: got %0d pulses %0d busy cycles black=%0d expected 0 0 2", n, nb, score_black);
        end
    endtask

    task automatic test_lanes4();
        int n = 0, at = -1;
        logic b15 = 1'b0, b16 = 1'b1;
        board4 = fill(3'b110);
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int j = 1; j <= 30; j++) begin
            tick();
            if (j == 15) b15 = busy4;
            if (j == 16) b16 = busy4;
            if (count_done4) begin
                n++;
                if (at < 0) at = j;
            end
        end
        n_checks++;
        if (n !== 1 || at !== 17 || {b15, b16} !== 2'b10) begin
            n_fail++;
            $display("FAIL lanes4_timing: got %0d pulses at k+%0d busy15/16=%b%b expected 1 at k+17 busy 10", n, at, b15, b16);
        end
        n_checks++;
        if ({score_white4, score_black4, score_empty4, leader4, all_filled4, wiped4} !== {7'd64, 7'd0, 7'd0, 2'b01, 2'b11}) begin
            n_fail++;
            $display("FAIL lanes4_result: got %0d/%0d/%0d leader=%b af=%b wp=%b expected 64/0/0 01 1 1",
                     score_white4, score_black4, score_empty4, leader4, all_filled4, wiped4);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_opening();
        test_invalid_codes();
        test_snapshot();
        test_back_to_back();
        test_reset_mid_scan();
        test_init_mid_scan();
        test_init_start_same();
        test_lanes4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/board_score_counter.md
# board_score_counter

Parametrised piece-count engine for the reversi datapath. On a `start` pulse it snapshots the packed board and scans it `LANES` cells per cycle. It then publishes white, black and empty counts, the current leader, and end-of-game flags atomically, with a one-cycle `done` pulse. It sits between the move-apply logic and the game FSM: the FSM issues `start` after each turn and waits for `done` before evaluating the game-over condition.

## Interface
- `N_CELLS`, 64: number of board cells; must be a multiple of `LANES`.
- `CELL_W`, 3: bits per cell in the packed board.
- `WHITE_CODE`, 3'b110: cell code for a white piece.
- `BLACK_CODE`, 3'b111: cell code for a black piece; any other code counts as empty.
- `LANES`, 1: cells examined per scan cycle; legal values 1, 2, 4, 8.
- Derived, not overridable: `SCORE_W = $clog2(N_CELLS+1)`; `STEPS = N_CELLS/LANES`.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `resetn`, in, 1: asynchronous, active-high reset (the name is historical; a high level resets).
- `init`, in, 1: synchronous; aborts any scan and loads opening-position scores.
- `start`, in, 1: request a count; sampled only in IDLE.
- `curr_board`, in, `N_CELLS*CELL_W`: packed board; cell i occupies bits `[i*CELL_W +: CELL_W]`.
- `busy`, out, 1: high while in SCAN.
- `count_done`, out, 1: one-cycle pulse when new results are published.
- `score_white`, out, `SCORE_W`: count of white pieces.
- `score_black`, out, `SCORE_W`: count of black pieces.
- `score_empty`, out, `SCORE_W`: count of empty cells.
- `leader`, out, 2: 2'b00 tie, 2'b01 white ahead, 2'b10 black ahead; 2'b11 is never driven.
- `all_filled`, out, 1: `score_empty == 0`.
- `wiped`, out, 1: exactly one colour count is 0 and the board is not entirely empty.

## Operation
- States: IDLE, SCAN, PUBLISH.
  - IDLE → SCAN on `start`.
  - SCAN → PUBLISH after `STEPS` cycles.
  - PUBLISH → IDLE unconditionally.
- On `start` accepted in IDLE:
  - `curr_board` is copied into an internal snapshot register.
  - The cell index and the private white/black accumulators clear to 0.
  - Later changes to `curr_board` do not affect the result.
- SCAN, each cycle:
  - Cells `idx .. idx+LANES-1` of the snapshot are classified.
  - The accumulators add the per-cycle white and black hit counts, each 0..`LANES`.
  - `idx` advances by `LANES`.
- PUBLISH:
  - All score outputs, `leader`, `all_filled` and `wiped` update together from the accumulators.
  - `score_empty = N_CELLS - white - black`.
  - `count_done` is high for this cycle only.
- Published outputs hold their previous values during SCAN; they change only in PUBLISH, on `init`, or on reset.
- `start` while in SCAN or PUBLISH is ignored; no queueing.
- `init` (any state) forces IDLE and loads the opening values: white=2, black=2, empty=`N_CELLS-4`, leader=00, flags 0. No `count_done` is produced.
  - `init` and `start` in the same cycle: `init` wins and `start` is dropped.
- Arithmetic:
  - Accumulators are `SCORE_W` bits wide and cannot overflow.
  - The subtraction for the empty count is unsigned and always ≥ 0.

## Timing
- Reset values:
  - `busy`=0, `count_done`=0.
  - `score_white`=2, `score_black`=2, `score_empty`=`N_CELLS-4`.
  - `leader`=00, `all_filled`=0, `wiped`=0.
  - State is IDLE and the accumulators are 0.
- Latency, for `start` sampled high at rising edge k in IDLE:
  - `busy` is high for cycles k+1 .. k+`STEPS`.
  - New outputs and `count_done`=1 are visible after edge k+`STEPS`+1.
  - `busy` is 0 in that cycle.
  - Default parameters: `count_done` at k+65; with `LANES`=4, at k+17.
- Back-to-back: the earliest next accepted `start` is at edge k+`STEPS`+2, giving a throughput of one count per `STEPS`+2 cycles.
- `resetn` asserted mid-scan:
  - Immediate return to reset values, with no `count_done`.
  - After deassertion the block is in IDLE and accepts `start` on the next edge.

## Test plan
- Reset/idle: assert `resetn` → scores 2/2/60, `leader`=00, `busy`=0, `count_done`=0; hold `start` low for 100 cycles → no output change.
- Opening board: cells 27 and 36 white, 28 and 35 black, the rest 3'b000; `start` at edge k → `count_done` at k+65 only, with 2/2/60, `leader`=00, `all_filled`=0, `wiped`=0.
- Full white board, `LANES`=4: → `count_done` at k+17, with 64/0/0, `leader`=01, `all_filled`=1, `wiped`=1.
- Snapshot and ignored start:
  - Start on the opening board; at k+10 change `curr_board` to all black and pulse `start` again.
  - Required: result 2/2/60, exactly one `count_done`, and outputs unchanged from their prior values until k+65.
- Init mid-scan: 33 black and 31 white, start, then `init` at k+20 → `busy`=0 at k+21, scores 2/2/60, no `count_done` in the following 80 cycles.
- Invalid codes: every cell 3'b101 except 5 black → 0/5/59, `leader`=10, `wiped`=1; also assert `init` and `start` in the same cycle → no scan starts.
